// File: rtl/hamming_pkg.sv
// Shared widths and FSM state type for the Hamming-distance accumulator.
package hamming_pkg;
  localparam int WORD_W = 32;
  localparam int PC_W   = 6;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } hacc_state_t;
endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit word.
module popcount32
  import hamming_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [PC_W-1:0]   count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < WORD_W; i++) count = count + PC_W'(word[i]);
  end
endmodule

// File: rtl/hamming_accum.sv
// Streaming Hamming-distance accumulator: XOR stage, popcount, running sum, held result.
// Define HAMMING_ACCUM_SAT_EN to clamp the sum on overflow instead of wrapping.
module hamming_accum
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_dist,
  output logic              out_ovf
);
  hacc_state_t       state, state_nx;
  logic [WORD_W-1:0] x1;
  logic              v1, l1;
  logic [CNT_W-1:0]  acc;
  logic              ovf;
  logic [PC_W-1:0]   cnt;
  logic [CNT_W:0]    sum;
  logic              accept;
  logic              consume;

  assign in_ready  = (state == RUN);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign consume   = (state == HOLD) && out_ready;
  assign out_dist  = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        x1 <= in_a ^ in_b;
        l1 <= in_last;
      end
    end
  end

  popcount32 u_pc (
    .word  (x1),
    .count (cnt)
  );

  // One extra bit holds the carry out that drives overflow detection.
  assign sum = {1'b0, acc} + (CNT_W+1)'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (consume) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (v1) begin
`ifdef HAMMING_ACCUM_SAT_EN
      acc <= sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
      acc <= sum[CNT_W-1:0];
`endif
      ovf <= ovf | sum[CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (accept && in_last) state_nx = FLUSH;
      FLUSH:   state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // FLUSH always follows an accepted last beat, so stage 1 must hold it.
  a_flush_has_last: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FLUSH) |-> (v1 && l1));
endmodule

// File: tb/tb_hamming_accum.sv
// Directed table-driven bench for hamming_accum at CNT_W=16 and CNT_W=6 side by side.
module tb_hamming_accum;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_dist;
  logic        in_ready6, out_valid6, out_ovf6;
  logic [5:0]  out_dist6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_accum #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_dist(out_dist), .out_ovf(out_ovf)
  );

  hamming_accum #(.CNT_W(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid6),
    .out_ready(out_ready), .out_dist(out_dist6), .out_ovf(out_ovf6)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    int          gap;
    int          hold;
    logic [15:0] exp16;
    logic        ovf16;
    logic [5:0]  exp6;
    logic        ovf6;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    chk("in_ready_before_beat", 32'(in_ready), 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_a = $urandom; in_b = $urandom;
  endtask

  task automatic finish_stream(input logic [15:0] e16, input logic o16,
                               input logic [5:0] e6, input logic o6, input int hold);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    tick();
    chk("latency_out_valid", 32'(out_valid), 1);
    chk("latency_out_valid6", 32'(out_valid6), 1);
    chk("dist16", 32'(out_dist), 32'(e16));
    chk("ovf16", 32'(out_ovf), 32'(o16));
    chk("dist6", 32'(out_dist6), 32'(e6));
    chk("ovf6", 32'(out_ovf6), 32'(o6));
    // Garbage offered while holding must be ignored.
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = '0; in_last = 1'b1;
      tick();
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_dist", 32'(out_dist), 32'(e16));
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("restart_in_ready", 32'(in_ready), 1);
    chk("restart_out_valid", 32'(out_valid), 0);
    chk("restart_dist_clear", 32'(out_dist), 0);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0, 16'd32, 1'b0, 6'd32, 1'b0};
    vecs[1] = '{32'h0000_000F, 32'h0, 1'b0, 1, 0, 16'd0, 1'b0, 6'd0, 1'b0};
    vecs[2] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1, 0, 16'd0, 1'b0, 6'd0, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 0, 5, 16'd36, 1'b0, 6'd36, 1'b0};
    vecs[4] = '{32'h0000_0001, 32'h0, 1'b1, 0, 0, 16'd1, 1'b0, 6'd1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0, 16'd0, 1'b0, 6'd0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 0, 0, 16'd0, 1'b0, 6'd0, 1'b0};
`ifdef HAMMING_ACCUM_SAT_EN
    vecs[7] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 0, 2, 16'd96, 1'b0, 6'd63, 1'b1};
`else
    vecs[7] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 0, 2, 16'd96, 1'b0, 6'd32, 1'b1};
`endif
    vecs[8] = '{32'h0000_0003, 32'h0, 1'b1, 0, 0, 16'd2, 1'b0, 6'd2, 1'b0};

    #3;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_dist", 32'(out_dist), 0);
    chk("reset_out_ovf", 32'(out_ovf), 0);
    #14 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].last);
      if (vecs[i].last)
        finish_stream(vecs[i].exp16, vecs[i].ovf16, vecs[i].exp6, vecs[i].ovf6, vecs[i].hold);
      else
        repeat (vecs[i].gap) tick();
    end

    // Reset in the middle of a stream discards the partial sum.
    send(32'hFFFF_FFFF, 32'h0, 1'b0);
    send(32'h0000_00FF, 32'h0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_dist", 32'(out_dist), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_in_ready", 32'(in_ready), 1);
    send(32'h0000_0003, 32'h0, 1'b1);
    finish_stream(16'd2, 1'b0, 6'd2, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
